// File: rtl/bp_burst_mem_responder_pkg.sv
// Shared types for the BedRock burst memory responder: command/response header layout,
// message type and size encodings, and the beat/byte-mask helpers derived from them.
package bp_burst_mem_responder_pkg;

    localparam int unsigned PADDR_W   = 40;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned CNT_W     = 3;

    typedef enum logic [3:0] {
        E_MEM_RD    = 4'd0,
        E_MEM_WR    = 4'd1,
        E_MEM_UC_RD = 4'd2,
        E_MEM_UC_WR = 4'd3,
        E_MEM_PRE   = 4'd4,
        E_MEM_AMO   = 4'd5
    } mem_msg_type_e;

    typedef enum logic [2:0] {
        E_SIZE_1   = 3'd0,
        E_SIZE_2   = 3'd1,
        E_SIZE_4   = 3'd2,
        E_SIZE_8   = 3'd3,
        E_SIZE_16  = 3'd4,
        E_SIZE_32  = 3'd5,
        E_SIZE_64  = 3'd6,
        E_SIZE_128 = 3'd7
    } mem_msg_size_e;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        mem_msg_size_e        size;
        logic [PADDR_W-1:0]   addr;
        mem_msg_type_e        msg_type;
    } mem_msg_header_s;

    localparam int unsigned HDR_W = $bits(mem_msg_header_s);

    // Index of the final beat; a 128B request saturates at one 64B block.
    function automatic logic [CNT_W-1:0] last_beat(input mem_msg_size_e size);
        case (size)
            E_SIZE_16:             last_beat = 3'd1;
            E_SIZE_32:             last_beat = 3'd3;
            E_SIZE_64, E_SIZE_128: last_beat = 3'd7;
            default:               last_beat = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(input mem_msg_size_e size, input logic [2:0] offset);
        case (size)
            E_SIZE_1: byte_mask = 8'h01 << offset;
            E_SIZE_2: byte_mask = 8'h03 << offset;
            E_SIZE_4: byte_mask = 8'h0F << offset;
            default:  byte_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/bp_burst_mem_responder_sram.sv
// Single-port synchronous dword SRAM with byte-masked writes. Read data stays in the
// output register until the next read, so a stalled beat needs no re-read.
module bp_burst_mem_responder_sram #(
    parameter int unsigned els_p        = 4096,
    parameter int unsigned data_width_p = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_v,
    input  logic                       i_w,
    input  logic [$clog2(els_p)-1:0]   i_addr,
    input  logic [data_width_p-1:0]    i_data,
    input  logic [data_width_p/8-1:0]  i_mask,
    output logic [data_width_p-1:0]    o_data
);

    logic [data_width_p-1:0] r_mem [els_p];
    logic [data_width_p-1:0] r_data;

    // Byte-lane write port; array contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_v && i_w) begin
            for (int b = 0; b < data_width_p/8; b++) begin
                if (i_mask[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_data[8*b +: 8];
                end
            end
        end
    end

    // Read output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_v && !i_w) begin
            r_data <= r_mem[i_addr];
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/bp_burst_mem_responder.sv
// Memory-side endpoint for the BedRock burst mem interface: accepts cmd header/data
// streams and answers with resp header/data streams from an on-chip dword SRAM.
module bp_burst_mem_responder
    import bp_burst_mem_responder_pkg::*;
#(
    parameter int unsigned        data_width_p = 64,
    parameter int unsigned        mem_els_p    = 4096,
    parameter logic [PADDR_W-1:0] mem_base_p   = 40'h80_0000_0000
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [HDR_W-1:0]        mem_cmd_header_i,
    input  logic                    mem_cmd_header_v_i,
    output logic                    mem_cmd_header_ready_and_o,
    input  logic [data_width_p-1:0] mem_cmd_data_i,
    input  logic                    mem_cmd_data_v_i,
    output logic                    mem_cmd_data_ready_and_o,
    output logic [HDR_W-1:0]        mem_resp_header_o,
    output logic                    mem_resp_header_v_o,
    input  logic                    mem_resp_header_ready_and_i,
    output logic [data_width_p-1:0] mem_resp_data_o,
    output logic                    mem_resp_data_v_o,
    input  logic                    mem_resp_data_ready_and_i
);

    localparam int unsigned IDX_W = $clog2(mem_els_p);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_DATA  = 3'd1;
    localparam logic [2:0] ST_WR_HDR   = 3'd2;
    localparam logic [2:0] ST_RD_HDR   = 3'd3;
    localparam logic [2:0] ST_RD_ISSUE = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    mem_msg_header_s         r_hdr;
    mem_msg_header_s         w_cmd_hdr;
    logic                    w_hdr_load;
    logic                    r_cmd_hdr_ready;
    logic                    r_cmd_data_ready;
    logic                    r_resp_hdr_v;
    logic                    r_resp_data_v;
    logic                    w_cmd_is_wr;
    logic                    w_last_beat;
    logic                    w_beat_wr;
    logic                    w_sram_v;
    logic [CNT_W-1:0]        w_last;
    logic [IDX_W-1:0]        w_base_idx;
    logic [IDX_W-1:0]        w_wrap_mask;
    logic [IDX_W-1:0]        w_beat_idx;
    logic [data_width_p/8-1:0] w_mask;
    logic [data_width_p-1:0] w_sram_rdata;

    assign w_cmd_hdr   = mem_cmd_header_i;
    assign w_cmd_is_wr = (w_cmd_hdr.msg_type == E_MEM_WR) || (w_cmd_hdr.msg_type == E_MEM_UC_WR);
    assign w_last      = last_beat(r_hdr.size);
    assign w_last_beat = (r_cnt == w_last);
    assign w_beat_wr   = r_cmd_data_ready && mem_cmd_data_v_i;
    assign w_sram_v    = w_beat_wr || (r_state == ST_RD_ISSUE);
    assign w_mask      = byte_mask(r_hdr.size, r_hdr.addr[2:0]);

    // Critical-word-first: keep the block-aligned upper index, wrap the low bits by beat count.
    assign w_base_idx  = IDX_W'((r_hdr.addr - mem_base_p) >> 3'd3);
    assign w_wrap_mask = IDX_W'(w_last);
    assign w_beat_idx  = (w_base_idx & ~w_wrap_mask) | ((w_base_idx + IDX_W'(r_cnt)) & w_wrap_mask);

    // Next-state, beat counter and header-capture decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hdr_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_cmd_header_v_i && r_cmd_hdr_ready) begin
                    w_hdr_load  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_cmd_is_wr ? ST_WR_DATA : ST_RD_HDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (w_beat_wr) begin
                    if (w_last_beat) begin
                        w_state_nxt = ST_WR_HDR;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt = ST_WR_DATA;
                end
            end
            ST_WR_HDR: begin
                if (mem_resp_header_ready_and_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WR_HDR;
                end
            end
            ST_RD_HDR: begin
                if (mem_resp_header_ready_and_i) begin
                    w_state_nxt = ST_RD_ISSUE;
                end else begin
                    w_state_nxt = ST_RD_HDR;
                end
            end
            ST_RD_ISSUE: begin
                w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (mem_resp_data_ready_and_i) begin
                    if (w_last_beat) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = r_cnt + 3'd1;
                        w_state_nxt = ST_RD_ISSUE;
                    end
                end else begin
                    w_state_nxt = ST_RD_DATA;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, header and handshake flags; flags decode the next state so outputs are flopped.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_hdr            <= '0;
            r_cmd_hdr_ready  <= 1'b0;
            r_cmd_data_ready <= 1'b0;
            r_resp_hdr_v     <= 1'b0;
            r_resp_data_v    <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            if (w_hdr_load) begin
                r_hdr <= w_cmd_hdr;
            end
            r_cmd_hdr_ready  <= (w_state_nxt == ST_IDLE);
            r_cmd_data_ready <= (w_state_nxt == ST_WR_DATA);
            r_resp_hdr_v     <= (w_state_nxt == ST_WR_HDR) || (w_state_nxt == ST_RD_HDR);
            r_resp_data_v    <= (w_state_nxt == ST_RD_DATA);
        end
    end

    bp_burst_mem_responder_sram #(
        .els_p        (mem_els_p),
        .data_width_p (data_width_p)
    ) u_sram (
        .i_clk   (clk_i),
        .i_rst_n (reset_n_i),
        .i_v     (w_sram_v),
        .i_w     (w_beat_wr),
        .i_addr  (w_beat_idx),
        .i_data  (mem_cmd_data_i),
        .i_mask  (w_mask),
        .o_data  (w_sram_rdata)
    );

    assign mem_cmd_header_ready_and_o = r_cmd_hdr_ready;
    assign mem_cmd_data_ready_and_o   = r_cmd_data_ready;
    assign mem_resp_header_o          = r_hdr;
    assign mem_resp_header_v_o        = r_resp_hdr_v;
    assign mem_resp_data_o            = w_sram_rdata;
    assign mem_resp_data_v_o          = r_resp_data_v;

endmodule

// File: tb/tb_bp_burst_mem_responder.sv
// Scoreboard bench for bp_burst_mem_responder: stimulus pushes expected responses from a
// byte-level reference memory; a negedge monitor pops and compares on every handshake.
module tb_bp_burst_mem_responder;
    import bp_burst_mem_responder_pkg::*;

    localparam logic [39:0] MEM_BASE = 40'h80_0000_0000;
    localparam int          MEM_ELS  = 4096;

    logic             clk;
    logic             reset_n;
    logic [HDR_W-1:0] cmd_hdr;
    logic             cmd_hdr_v;
    logic             cmd_hdr_ready;
    logic [63:0]      cmd_data;
    logic             cmd_data_v;
    logic             cmd_data_ready;
    logic [HDR_W-1:0] resp_hdr;
    logic             resp_hdr_v;
    logic             resp_hdr_ready;
    logic [63:0]      resp_data;
    logic             resp_data_v;
    logic             resp_data_ready;

    bp_burst_mem_responder dut (
        .clk_i                       (clk),
        .reset_n_i                   (reset_n),
        .mem_cmd_header_i            (cmd_hdr),
        .mem_cmd_header_v_i          (cmd_hdr_v),
        .mem_cmd_header_ready_and_o  (cmd_hdr_ready),
        .mem_cmd_data_i              (cmd_data),
        .mem_cmd_data_v_i            (cmd_data_v),
        .mem_cmd_data_ready_and_o    (cmd_data_ready),
        .mem_resp_header_o           (resp_hdr),
        .mem_resp_header_v_o         (resp_hdr_v),
        .mem_resp_header_ready_and_i (resp_hdr_ready),
        .mem_resp_data_o             (resp_data),
        .mem_resp_data_v_o           (resp_data_v),
        .mem_resp_data_ready_and_i   (resp_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_vec = 0;
    int               n_err = 0;
    logic [63:0]      ref_mem [MEM_ELS];
    logic [HDR_W-1:0] exp_hdr_q [$];
    logic [63:0]      exp_data_q [$];
    logic [63:0]      wbeats [8];
    bit               hold_hdr = 1'b0;
    bit               hold_data = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbeats(input int sz);
        int b;
        b = (1 << sz) / 8;
        if (b < 1) b = 1;
        if (b > 8) b = 8;
        return b;
    endfunction

    // Dword index of beat k: block-aligned, wrapping from the requested dword.
    function automatic int beat_idx(input logic [39:0] addr, input int sz, input int k);
        logic [39:0] off;
        int idx, nb;
        off = addr - MEM_BASE;
        idx = int'((off >> 3) % MEM_ELS);
        nb  = nbeats(sz);
        return (idx - (idx % nb)) + ((idx % nb) + k) % nb;
    endfunction

    // Consumer-side ready: random unless a hold is requested.
    initial begin
        resp_hdr_ready  = 1'b0;
        resp_data_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            resp_hdr_ready  = hold_hdr  ? 1'b0 : ($urandom_range(0, 3) != 0);
            resp_data_ready = hold_data ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every response handshake pops and checks the oldest expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            if (resp_hdr_v && resp_hdr_ready) begin
                if (exp_hdr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL resp_hdr_unexpected: got %h expected none", resp_hdr);
                end else begin
                    chk("resp_hdr", 64'(resp_hdr), 64'(exp_hdr_q.pop_front()));
                end
            end
            if (resp_data_v && resp_data_ready) begin
                if (exp_data_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL resp_data_unexpected: got %h expected none", resp_data);
                end else begin
                    chk("resp_data", resp_data, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input mem_msg_header_s h);
        bit ok;
        ok = 1'b0;
        gap();
        cmd_hdr   = h;
        cmd_hdr_v = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_hdr_ready;
            @(posedge clk);
            #1;
        end
        cmd_hdr_v = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL cmd_hdr_timeout: ready got 0 expected 1");
        end
    endtask

    task automatic send_beat(input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        gap();
        cmd_data   = d;
        cmd_data_v = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cmd_data_ready;
            @(posedge clk);
            #1;
        end
        cmd_data_v = 1'b0;
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL cmd_data_timeout: ready got 0 expected 1");
        end
    endtask

    function automatic mem_msg_header_s mk_hdr(input int mt, input int sz, input logic [39:0] addr);
        mem_msg_header_s h;
        h.msg_type = mem_msg_type_e'(mt[3:0]);
        h.size     = mem_msg_size_e'(sz[2:0]);
        h.addr     = addr;
        h.payload  = 16'($urandom);
        return h;
    endfunction

    // Apply beat k of a write to the reference memory.
    task automatic model_write(input logic [39:0] addr, input int sz, input int k);
        int idx, off, n;
        idx = beat_idx(addr, sz, k);
        if (sz < 3) begin
            off = int'(addr[2:0]);
            n   = 1 << sz;
            for (int b = 0; b < 8; b++) begin
                if (b >= off && b < off + n) ref_mem[idx][8*b +: 8] = wbeats[0][8*b +: 8];
            end
        end else begin
            ref_mem[idx] = wbeats[k];
        end
    endtask

    // Full transaction: expectations first, then drive header and (for writes) beats.
    task automatic do_txn(input int mt, input int sz, input logic [39:0] addr);
        mem_msg_header_s h;
        bit is_wr;
        h     = mk_hdr(mt, sz, addr);
        is_wr = (mt == 1) || (mt == 3);
        exp_hdr_q.push_back(h);
        for (int k = 0; k < nbeats(sz); k++) begin
            if (is_wr) model_write(addr, sz, k);
            else exp_data_q.push_back(ref_mem[beat_idx(addr, sz, k)]);
        end
        send_hdr(h);
        if (is_wr) begin
            for (int k = 0; k < nbeats(sz); k++) send_beat(wbeats[k]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_data_q.size() != 0 || !cmd_hdr_ready) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 500) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: pending hdr %0d data %0d expected 0", exp_hdr_q.size(), exp_data_q.size());
        end
    endtask

    task automatic wait_v(input bit which_data);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = which_data ? resp_data_v : resp_hdr_v;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL wait_valid_timeout: valid got 0 expected 1");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_msg_header_s h5;
        reset_n    = 1'b0;
        cmd_hdr    = '0;
        cmd_hdr_v  = 1'b0;
        cmd_data   = 64'd0;
        cmd_data_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
        chk("rst_cmd_data_ready", 64'(cmd_data_ready), 64'd0);
        chk("rst_resp_hdr_v", 64'(resp_hdr_v), 64'd0);
        chk("rst_resp_data_v", 64'(resp_data_v), 64'd0);
        chk("rst_resp_hdr", 64'(resp_hdr), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_cmd_hdr_ready", 64'(cmd_hdr_ready), 64'd1);
        @(posedge clk);
        #1;

        // Prefill dwords 0..255 with known random data via 64B writes.
        for (int blk = 0; blk < 32; blk++) begin
            for (int k = 0; k < 8; k++) wbeats[k] = {$urandom, $urandom};
            do_txn(1, 6, 40'h00_8000_0000 + 40'(blk * 64));
        end
        drain();

        // Single dword write then read back.
        wbeats[0] = 64'hDEAD_BEEF_0123_4567;
        do_txn(1, 3, 40'h00_8000_0008);
        do_txn(0, 3, 40'h00_8000_0008);
        drain();

        // 64B block then critical-word-first read from the fourth dword.
        for (int k = 0; k < 8; k++) wbeats[k] = 64'(k);
        do_txn(1, 6, 40'h00_8000_0040);
        do_txn(0, 6, 40'h00_8000_0058);
        drain();

        // Single-byte write merged into an existing dword.
        wbeats[0] = 64'h1111_1111_1111_1111;
        do_txn(1, 3, 40'h00_8000_0000);
        wbeats[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        do_txn(0 + 1, 0, 40'h00_8000_0003);
        do_txn(0, 3, 40'h00_8000_0000);
        drain();

        // Consumer stall on a 64B read: valid and values must hold, no new command accepted.
        hold_hdr  = 1'b1;
        hold_data = 1'b1;
        @(posedge clk);
        #1;
        do_txn(0, 6, 40'h00_8000_0040);
        wait_v(1'b0);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hdr_v", 64'(resp_hdr_v), 64'd1);
            chk("stall_hdr_val", 64'(resp_hdr), 64'(exp_hdr_q[0]));
            chk("stall_cmd_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
        end
        hold_hdr = 1'b0;
        wait_v(1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("stall_data_v", 64'(resp_data_v), 64'd1);
            chk("stall_data_val", resp_data, exp_data_q[0]);
            chk("stall_cmd_hdr_ready2", 64'(cmd_hdr_ready), 64'd0);
        end
        hold_data = 1'b0;
        @(posedge clk);
        #1;
        drain();

        // Reset during beat 3 of a 64B write: beats 0-2 land, the rest keep old data.
        h5 = mk_hdr(1, 6, 40'h00_8000_0100);
        send_hdr(h5);
        for (int k = 0; k < 3; k++) begin
            wbeats[k] = {$urandom, $urandom};
            model_write(40'h00_8000_0100, 6, k);
            send_beat(wbeats[k]);
        end
        cmd_data   = {$urandom, $urandom};
        cmd_data_v = 1'b1;
        @(negedge clk);
        chk("abort_data_ready_pre", 64'(cmd_data_ready), 64'd1);
        reset_n    = 1'b0;
        cmd_data_v = 1'b0;
        #1;
        chk("abort_cmd_data_ready", 64'(cmd_data_ready), 64'd0);
        chk("abort_cmd_hdr_ready", 64'(cmd_hdr_ready), 64'd0);
        chk("abort_resp_hdr_v", 64'(resp_hdr_v), 64'd0);
        chk("abort_resp_hdr", 64'(resp_hdr), 64'd0);
        @(posedge clk);
        #1;
        chk("abort_edge_data_ready", 64'(cmd_data_ready), 64'd0);
        chk("abort_edge_resp_data_v", 64'(resp_data_v), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_idle_hdr_ready", 64'(cmd_hdr_ready), 64'd1);
        chk("abort_idle_data_ready", 64'(cmd_data_ready), 64'd0);
        @(posedge clk);
        #1;
        do_txn(0, 6, 40'h00_8000_0100);
        drain();

        // Random mix of reads, writes and other message types with random gaps.
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < 8; k++) wbeats[k] = {$urandom, $urandom};
            do_txn($urandom_range(0, 4), $urandom_range(0, 6), 40'h00_8000_0000 + 40'($urandom_range(0, 2047)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
